// File: rtl/switch_activity_monitor_pkg.sv
// Shared types, default sizes and arithmetic helpers for the switching-activity monitor.
package act_mon_pkg;

   localparam int N_IN_DEF       = 16;
   localparam int WINDOW_LEN_DEF = 256;
   localparam int CNT_W_DEF      = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      REPORT = 2'd2
   } state_e;

   // Saturating add on zero-extended operands. Bit 32 of the result flags a clamp;
   // bits [31:0] hold min(a + b, max_val).
   function automatic logic [32:0] sat_add(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [31:0] max_val);
      logic [32:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      if (sum > {1'b0, max_val}) begin
         return {1'b1, max_val};
      end
      return sum;
   endfunction

endpackage

// File: rtl/switch_activity_monitor_toggle_popcount.sv
// Combinational Hamming distance between two vectors (XOR then population count).
module toggle_popcount
   import act_mon_pkg::*;
#(
   parameter int N_IN  = N_IN_DEF,
   parameter int OUT_W = $clog2(N_IN + 1)
) (
   input  logic [N_IN-1:0]  vec_a,
   input  logic [N_IN-1:0]  vec_b,
   output logic [OUT_W-1:0] count
);

   logic [N_IN-1:0] diff;

   assign diff = vec_a ^ vec_b;

   // Count the set bits of the difference vector.
   always_comb begin
      count = '0;
      for (int i = 0; i < N_IN; i++) begin
         count = count + OUT_W'(diff[i]);
      end
   end

endmodule

// File: rtl/switch_activity_monitor.sv
// Windowed input/output toggle counter feeding switching-activity totals to a
// valid/ready result port. One window = WINDOW_LEN accepted samples.
module switch_activity_monitor
   import act_mon_pkg::*;
#(
   parameter int N_IN       = N_IN_DEF,
   parameter int WINDOW_LEN = WINDOW_LEN_DEF,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N_IN-1:0]  in_vec,
   input  logic             in_resp,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [CNT_W-1:0] res_in_toggles,
   output logic [CNT_W-1:0] res_out_toggles,
   output logic [CNT_W-1:0] res_samples,
   output logic             res_sat,
   output logic             busy
);

   localparam int          PC_W    = $clog2(N_IN + 1);
   localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

   state_e           state_q, state_d;
   logic             in_ready_q, in_ready_d;
   logic             res_valid_q, res_valid_d;
   logic             busy_q, busy_d;
   logic             first_q, first_d;
   logic             sat_q, sat_d;
   logic [N_IN-1:0]  prev_vec_q, prev_vec_d;
   logic             prev_resp_q, prev_resp_d;
   logic [CNT_W-1:0] in_acc_q, in_acc_d;
   logic [CNT_W-1:0] out_acc_q, out_acc_d;
   logic [CNT_W-1:0] samp_q, samp_d;
   logic [CNT_W-1:0] res_in_q, res_in_d;
   logic [CNT_W-1:0] res_out_q, res_out_d;
   logic [CNT_W-1:0] res_samp_q, res_samp_d;

   logic [PC_W-1:0]  beat_toggles;
   logic [32:0]      in_sum;
   logic [32:0]      out_sum;
   logic             accept;
   logic             handshake;
   logic             arm;

   toggle_popcount #(
      .N_IN  (N_IN),
      .OUT_W (PC_W)
   ) u_popcount (
      .vec_a (in_vec),
      .vec_b (prev_vec_q),
      .count (beat_toggles)
   );

   assign accept    = in_valid & in_ready_q;
   assign handshake = res_valid_q & res_ready;
   assign in_sum    = sat_add(32'(in_acc_q), 32'(beat_toggles), CNT_MAX);
   assign out_sum   = sat_add(32'(out_acc_q), 32'(in_resp ^ prev_resp_q), CNT_MAX);

   // Next-state, accumulation and result capture; handshake outputs are a
   // registered decode of the next state so they line up with the state register.
   always_comb begin
      state_d     = state_q;
      first_d     = first_q;
      sat_d       = sat_q;
      prev_vec_d  = prev_vec_q;
      prev_resp_d = prev_resp_q;
      in_acc_d    = in_acc_q;
      out_acc_d   = out_acc_q;
      samp_d      = samp_q;
      res_in_d    = res_in_q;
      res_out_d   = res_out_q;
      res_samp_d  = res_samp_q;
      arm         = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               arm = 1'b1;
            end
         end
         ACCUM: begin
            if (accept) begin
               samp_d      = samp_q + CNT_W'(1);
               prev_vec_d  = in_vec;
               prev_resp_d = in_resp;
               first_d     = 1'b0;
               // The first sample of a window only seeds the previous vector.
               if (!first_q) begin
                  in_acc_d  = CNT_W'(in_sum[31:0]);
                  out_acc_d = CNT_W'(out_sum[31:0]);
                  if (in_sum[32] || out_sum[32]) begin
                     sat_d = 1'b1;
                  end
               end
               if (samp_d == CNT_W'(WINDOW_LEN)) begin
                  state_d    = REPORT;
                  res_in_d   = in_acc_d;
                  res_out_d  = out_acc_d;
                  res_samp_d = samp_d;
               end
            end
         end
         REPORT: begin
            if (handshake) begin
               state_d = IDLE;
               if (start) begin
                  arm = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (arm) begin
         state_d   = ACCUM;
         in_acc_d  = '0;
         out_acc_d = '0;
         samp_d    = '0;
         sat_d     = 1'b0;
         first_d   = 1'b1;
      end

      in_ready_d  = (state_d == ACCUM);
      res_valid_d = (state_d == REPORT);
      busy_d      = (state_d != IDLE);
   end

   // State and datapath registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b0;
         res_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         first_q     <= 1'b1;
         sat_q       <= 1'b0;
         prev_vec_q  <= '0;
         prev_resp_q <= 1'b0;
         in_acc_q    <= '0;
         out_acc_q   <= '0;
         samp_q      <= '0;
         res_in_q    <= '0;
         res_out_q   <= '0;
         res_samp_q  <= '0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         res_valid_q <= res_valid_d;
         busy_q      <= busy_d;
         first_q     <= first_d;
         sat_q       <= sat_d;
         prev_vec_q  <= prev_vec_d;
         prev_resp_q <= prev_resp_d;
         in_acc_q    <= in_acc_d;
         out_acc_q   <= out_acc_d;
         samp_q      <= samp_d;
         res_in_q    <= res_in_d;
         res_out_q   <= res_out_d;
         res_samp_q  <= res_samp_d;
      end
   end

   assign in_ready        = in_ready_q;
   assign res_valid       = res_valid_q;
   assign busy            = busy_q;
   assign res_sat         = sat_q;
   assign res_in_toggles  = res_in_q;
   assign res_out_toggles = res_out_q;
   assign res_samples     = res_samp_q;

endmodule

// File: tb/tb_switch_activity_monitor.sv
// Randomized bench for switch_activity_monitor: a default-size instance (index 0)
// and a narrow-counter instance (index 1, CNT_W=8, WINDOW_LEN=20).
module tb_switch_activity_monitor;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        start[2];
   logic        in_valid[2];
   logic        in_resp[2];
   logic        res_ready[2];
   logic [15:0] in_vec[2];

   logic        in_ready_o[2];
   logic        res_valid_o[2];
   logic        res_sat_o[2];
   logic        busy_o[2];
   logic [15:0] rin_o[2];
   logic [15:0] rout_o[2];
   logic [15:0] rsamp_o[2];

   logic        m_in_ready, m_res_valid, m_res_sat, m_busy;
   logic [15:0] m_rin, m_rout, m_rsamp;
   logic        s_in_ready, s_res_valid, s_res_sat, s_busy;
   logic [7:0]  s_rin, s_rout, s_rsamp;

   int checks = 0;
   int errors = 0;
   int wlen[2] = '{256, 20};
   int maxv[2] = '{65535, 255};

   logic [15:0] vq[$];
   logic        rq[$];

   switch_activity_monitor #(.N_IN(16), .WINDOW_LEN(256), .CNT_W(16)) u_main (
      .clk(clk), .rst(rst), .start(start[0]), .in_valid(in_valid[0]),
      .in_ready(m_in_ready), .in_vec(in_vec[0]), .in_resp(in_resp[0]),
      .res_valid(m_res_valid), .res_ready(res_ready[0]),
      .res_in_toggles(m_rin), .res_out_toggles(m_rout), .res_samples(m_rsamp),
      .res_sat(m_res_sat), .busy(m_busy)
   );

   switch_activity_monitor #(.N_IN(16), .WINDOW_LEN(20), .CNT_W(8)) u_small (
      .clk(clk), .rst(rst), .start(start[1]), .in_valid(in_valid[1]),
      .in_ready(s_in_ready), .in_vec(in_vec[1]), .in_resp(in_resp[1]),
      .res_valid(s_res_valid), .res_ready(res_ready[1]),
      .res_in_toggles(s_rin), .res_out_toggles(s_rout), .res_samples(s_rsamp),
      .res_sat(s_res_sat), .busy(s_busy)
   );

   assign in_ready_o[0]  = m_in_ready;
   assign res_valid_o[0] = m_res_valid;
   assign res_sat_o[0]   = m_res_sat;
   assign busy_o[0]      = m_busy;
   assign rin_o[0]       = m_rin;
   assign rout_o[0]      = m_rout;
   assign rsamp_o[0]     = m_rsamp;
   assign in_ready_o[1]  = s_in_ready;
   assign res_valid_o[1] = s_res_valid;
   assign res_sat_o[1]   = s_res_sat;
   assign busy_o[1]      = s_busy;
   assign rin_o[1]       = {8'h00, s_rin};
   assign rout_o[1]      = {8'h00, s_rout};
   assign rsamp_o[1]     = {8'h00, s_rsamp};

   // Reference: totals over the accepted beats of one window, clamped at the counter max.
   function automatic logic [48:0] model(input int d);
      int tin = 0;
      int tout = 0;
      logic sat;
      for (int i = 1; i < vq.size(); i++) begin
         tin  += $countones(vq[i] ^ vq[i-1]);
         tout += (rq[i] != rq[i-1]) ? 1 : 0;
      end
      sat = (tin > maxv[d]) || (tout > maxv[d]);
      if (tin > maxv[d]) tin = maxv[d];
      if (tout > maxv[d]) tout = maxv[d];
      return {sat, 16'(vq.size()), 16'(tout), 16'(tin)};
   endfunction

   function automatic logic [48:0] observed(input int d);
      return {res_sat_o[d], rsamp_o[d], rout_o[d], rin_o[d]};
   endfunction

   task automatic do_start(input int d);
      start[d] = 1'b1;
      @(posedge clk); #1;
      start[d] = 1'b0;
   endtask

   task automatic handshake(input int d, input bit with_start);
      res_ready[d] = 1'b1;
      start[d]     = with_start;
      @(posedge clk); #1;
      res_ready[d] = 1'b0;
      start[d]     = 1'b0;
   endtask

   // mode 0: all zero; mode 1: alternating 0000/FFFF with resp 0/1; mode 2: random.
   task automatic feed(input int d, input int mode, input int gap_pct, input int n, input bit poke);
      int acc = 0;
      int budget = 0;
      logic [15:0] v;
      logic r, vld;
      vq.delete();
      rq.delete();
      while (acc < n) begin
         if (budget > 8 * n + 50) begin
            checks++;
            errors++;
            $display("FAIL feed_timeout dut=%0d accepted=%0d required=%0d", d, acc, n);
            break;
         end
         budget++;
         case (mode)
            0: begin v = 16'h0000; r = 1'b0; end
            1: begin v = (acc % 2 == 1) ? 16'hFFFF : 16'h0000; r = (acc % 2 == 1); end
            default: begin v = 16'($urandom); r = 1'($urandom); end
         endcase
         vld         = ($urandom_range(99) >= gap_pct);
         in_valid[d] = vld;
         in_vec[d]   = v;
         in_resp[d]  = r;
         start[d]    = poke && ($urandom_range(7) == 0);
         if (vld && in_ready_o[d]) begin
            vq.push_back(v);
            rq.push_back(r);
            acc++;
         end
         @(posedge clk); #1;
      end
      in_valid[d] = 1'b0;
      start[d]    = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if ({in_ready_o[d], res_valid_o[d], busy_o[d], res_sat_o[d]} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl dut=%0d got=%b required=0000", d,
                     {in_ready_o[d], res_valid_o[d], busy_o[d], res_sat_o[d]});
         end
         checks++;
         if (observed(d) !== 49'd0) begin
            errors++;
            $display("FAIL reset_bus dut=%0d got=%h required=0", d, observed(d));
         end
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_window(input int mode, input string name);
      logic [48:0] exp;
      do_start(0);
      checks++;
      if (in_ready_o[0] !== 1'b1 || busy_o[0] !== 1'b1) begin
         errors++;
         $display("FAIL %s_armed in_ready=%b busy=%b required 1/1", name, in_ready_o[0], busy_o[0]);
      end
      feed(0, mode, 0, 256, 0);
      checks++;
      if (res_valid_o[0] !== 1'b1 || in_ready_o[0] !== 1'b0) begin
         errors++;
         $display("FAIL %s_latency res_valid=%b in_ready=%b required 1/0", name, res_valid_o[0], in_ready_o[0]);
      end
      exp = model(0);
      checks++;
      if (observed(0) !== exp) begin
         errors++;
         $display("FAIL %s_result got=%h required=%h", name, observed(0), exp);
      end
      handshake(0, 1'b0);
      checks++;
      if (res_valid_o[0] !== 1'b0 || busy_o[0] !== 1'b0 || in_ready_o[0] !== 1'b0) begin
         errors++;
         $display("FAIL %s_release res_valid=%b busy=%b in_ready=%b required 0/0/0", name,
                  res_valid_o[0], busy_o[0], in_ready_o[0]);
      end
   endtask

   task automatic test_gaps_stall();
      logic [48:0] exp;
      do_start(0);
      feed(0, 2, 40, 256, 1);
      checks++;
      if (res_valid_o[0] !== 1'b1) begin
         errors++;
         $display("FAIL gaps_latency res_valid=%b required 1", res_valid_o[0]);
      end
      exp = model(0);
      for (int c = 0; c < 10; c++) begin
         in_valid[0] = 1'b1;
         in_vec[0]   = 16'($urandom);
         start[0]    = 1'($urandom);
         res_ready[0] = 1'b0;
         @(posedge clk); #1;
         checks++;
         if (res_valid_o[0] !== 1'b1 || in_ready_o[0] !== 1'b0 || observed(0) !== exp) begin
            errors++;
            $display("FAIL stall_hold cyc=%0d res_valid=%b in_ready=%b got=%h required 1/0/%h",
                     c, res_valid_o[0], in_ready_o[0], observed(0), exp);
         end
      end
      in_valid[0] = 1'b0;
      start[0]    = 1'b0;
      handshake(0, 1'b0);
      checks++;
      if (res_valid_o[0] !== 1'b0 || busy_o[0] !== 1'b0) begin
         errors++;
         $display("FAIL stall_release res_valid=%b busy=%b required 0/0", res_valid_o[0], busy_o[0]);
      end
   endtask

   task automatic test_saturation();
      logic [48:0] exp;
      do_start(1);
      feed(1, 1, 0, 20, 0);
      exp = model(1);
      checks++;
      if (res_valid_o[1] !== 1'b1 || observed(1) !== exp) begin
         errors++;
         $display("FAIL sat_clamp res_valid=%b got=%h required 1/%h", res_valid_o[1], observed(1), exp);
      end
      handshake(1, 1'b0);
      do_start(1);
      checks++;
      if (res_sat_o[1] !== 1'b0) begin
         errors++;
         $display("FAIL sat_cleared got=%b required 0", res_sat_o[1]);
      end
      feed(1, 2, 20, 20, 0);
      exp = model(1);
      checks++;
      if (res_valid_o[1] !== 1'b1 || observed(1) !== exp) begin
         errors++;
         $display("FAIL sat_next_window res_valid=%b got=%h required 1/%h", res_valid_o[1], observed(1), exp);
      end
      handshake(1, 1'b0);
   endtask

   task automatic test_reset_mid();
      logic [48:0] exp;
      do_start(0);
      feed(0, 2, 10, 100, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         in_valid[0] = 1'b1;
         @(posedge clk); #1;
         checks++;
         if (res_valid_o[0] !== 1'b0 || busy_o[0] !== 1'b0 || in_ready_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL midrst_idle cyc=%0d res_valid=%b busy=%b in_ready=%b required 0/0/0",
                     c, res_valid_o[0], busy_o[0], in_ready_o[0]);
         end
      end
      in_valid[0] = 1'b0;
      do_start(0);
      feed(0, 2, 0, 256, 0);
      exp = model(0);
      checks++;
      if (res_valid_o[0] !== 1'b1 || observed(0) !== exp) begin
         errors++;
         $display("FAIL midrst_new_window res_valid=%b got=%h required 1/%h", res_valid_o[0], observed(0), exp);
      end
      handshake(0, 1'b0);
   endtask

   task automatic test_back_to_back();
      logic [48:0] exp;
      do_start(0);
      feed(0, 2, 0, 256, 0);
      exp = model(0);
      checks++;
      if (res_valid_o[0] !== 1'b1 || observed(0) !== exp) begin
         errors++;
         $display("FAIL b2b_first res_valid=%b got=%h required 1/%h", res_valid_o[0], observed(0), exp);
      end
      handshake(0, 1'b1);
      checks++;
      if (res_valid_o[0] !== 1'b0 || in_ready_o[0] !== 1'b1 || busy_o[0] !== 1'b1) begin
         errors++;
         $display("FAIL b2b_rearm res_valid=%b in_ready=%b busy=%b required 0/1/1",
                  res_valid_o[0], in_ready_o[0], busy_o[0]);
      end
      feed(0, 2, 25, 256, 0);
      exp = model(0);
      checks++;
      if (res_valid_o[0] !== 1'b1 || observed(0) !== exp) begin
         errors++;
         $display("FAIL b2b_second res_valid=%b got=%h required 1/%h", res_valid_o[0], observed(0), exp);
      end
      handshake(0, 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      for (int d = 0; d < 2; d++) begin
         start[d]     = 1'b0;
         in_valid[d]  = 1'b0;
         in_resp[d]   = 1'b0;
         res_ready[d] = 1'b0;
         in_vec[d]    = 16'h0000;
      end
      test_reset();
      test_window(0, "zeros");
      test_window(1, "alternate");
      test_gaps_stall();
      test_saturation();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
